// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the wave sequencer slice: FSM states,
// field-select encodings and default dimensions.
package wave_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] SEL_AMP    = 2'd0;
   localparam logic [1:0] SEL_OFFSET = 2'd1;
   localparam logic [1:0] SEL_PHASE  = 2'd2;

   localparam int N_CH_DEF = 64;
   localparam int DW_DEF   = 16;
   localparam int TW_DEF   = 16;

endpackage

// File: rtl/wave_param_bank.sv
// One parameter field (amp, offset or phase) for all channels: a shadow array
// written by the host and an active copy loaded in one edge on a bank swap.
module wave_param_bank
   import wave_seq_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int DW   = DW_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(N_CH)-1:0]  wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic                     load,
   output logic [N_CH*DW-1:0]       active
);

   localparam int AW = $clog2(N_CH);

   logic [DW-1:0] shadow [N_CH];

   // NOTE: both arrays are cleared on reset because their contents become
   // visible outputs on the very next load; leaving them X would leak out.
   // Decoding per channel means an address with no matching channel never writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) shadow[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (wr_en && wr_addr == AW'(i)) shadow[i] <= wr_data;
         end
      end
   end

   // A write on the load edge lands in the shadow only; active takes the old word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active <= '0;
      end else if (load) begin
         for (int i = 0; i < N_CH; i++) active[i*DW +: DW] <= shadow[i];
      end
   end

endmodule

// File: rtl/wave_sequencer.sv
// Segment sequencer for the DDS array: shadow/active banks swapped gaplessly
// at segment ends, with a cycle-counted segment timer.
// Optional macro WAVE_SEQ_LOOP_EN adds loop_mode (repeat the active bank).
module wave_sequencer
   import wave_seq_pkg::*;
#(
   parameter int N_CH = N_CH_DEF,
   parameter int DW   = DW_DEF,
   parameter int TW   = TW_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [1:0]               wr_sel,
   input  logic [$clog2(N_CH)-1:0]  wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic [TW-1:0]            seg_time,
   input  logic                     commit,
   input  logic                     abort,
`ifdef WAVE_SEQ_LOOP_EN
   input  logic                     loop_mode,
`endif
   output logic [N_CH*DW-1:0]       active_amps,
   output logic [N_CH*DW-1:0]       active_offsets,
   output logic [N_CH*DW-1:0]       active_phasewords,
   output logic                     dds_reset,
   output logic                     sample_valid,
   output logic                     timeup,
   output logic                     seg_done,
   output logic                     pending,
   output logic [15:0]              seg_count
);

   state_t        state;
   logic [TW-1:0] counter;
   logic [TW-1:0] seg_time_q;

   logic          seg_end;
   logic          have_bank;
   logic          do_load;
   logic          loop_reload;
   logic [TW-1:0] next_time;

   // NOTE: the load decision is combinational from registered state and the
   // inputs so the banks and the FSM act on the same edge; every output is
   // still taken from a flop.
   always_comb begin
      seg_end   = (state == RUN) && (abort || counter == '0);
      have_bank = pending || commit;
      do_load   = (state == IDLE) ? have_bank : (seg_end && have_bank);
      next_time = commit ? seg_time : seg_time_q;
`ifdef WAVE_SEQ_LOOP_EN
      loop_reload = seg_end && !have_bank && loop_mode && !abort;
`else
      loop_reload = 1'b0;
`endif
   end

   wave_param_bank #(.N_CH(N_CH), .DW(DW)) u_amp (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en && wr_sel == SEL_AMP),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .load    (do_load),
      .active  (active_amps)
   );

   wave_param_bank #(.N_CH(N_CH), .DW(DW)) u_offset (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en && wr_sel == SEL_OFFSET),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .load    (do_load),
      .active  (active_offsets)
   );

   wave_param_bank #(.N_CH(N_CH), .DW(DW)) u_phase (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en && wr_sel == SEL_PHASE),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .load    (do_load),
      .active  (active_phasewords)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         counter      <= '0;
         seg_time_q   <= '0;
         pending      <= 1'b0;
         dds_reset    <= 1'b0;
         seg_done     <= 1'b0;
         sample_valid <= 1'b0;
         timeup       <= 1'b1;
         seg_count    <= '0;
      end else begin
         dds_reset <= do_load || loop_reload;
         seg_done  <= seg_end;

         if (commit) seg_time_q <= seg_time;

         // A commit on the edge that consumes a pending bank queues another one.
         if (do_load)     pending <= pending && commit;
         else if (commit) pending <= 1'b1;

         if (do_load || loop_reload) seg_count <= seg_count + 16'd1;

         unique case (state)
            IDLE: begin
               if (do_load) begin
                  state        <= RUN;
                  counter      <= next_time;
                  sample_valid <= 1'b1;
                  timeup       <= 1'b0;
               end
            end
            RUN: begin
               if (do_load) begin
                  counter <= next_time;
               end else if (loop_reload) begin
                  counter <= seg_time_q;
               end else if (seg_end) begin
                  state        <= IDLE;
                  sample_valid <= 1'b0;
                  timeup       <= 1'b1;
               end else begin
                  counter <= counter - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wave_sequencer.sv
// Scoreboard bench for wave_sequencer: stimulus queues expected bank loads and
// segment records; a monitor pops them on dds_reset / seg_done pulses.
module tb_wave_sequencer;
   import wave_seq_pkg::*;

   localparam int N_CH = 64;
   localparam int DW   = 16;
   localparam int TW   = 16;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  wr_en = 1'b0;
   logic [1:0]            wr_sel = '0;
   logic [5:0]            wr_addr = '0;
   logic [DW-1:0]         wr_data = '0;
   logic [TW-1:0]         seg_time = '0;
   logic                  commit = 1'b0;
   logic                  abort = 1'b0;
`ifdef WAVE_SEQ_LOOP_EN
   logic                  loop_mode = 1'b0;
`endif
   logic [N_CH*DW-1:0]    active_amps, active_offsets, active_phasewords;
   logic                  dds_reset, sample_valid, timeup, seg_done, pending;
   logic [15:0]           seg_count;

   wave_sequencer #(.N_CH(N_CH), .DW(DW), .TW(TW)) dut (
      .clk               (clk),
      .reset             (reset),
      .wr_en             (wr_en),
      .wr_sel            (wr_sel),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .seg_time          (seg_time),
      .commit            (commit),
      .abort             (abort),
`ifdef WAVE_SEQ_LOOP_EN
      .loop_mode         (loop_mode),
`endif
      .active_amps       (active_amps),
      .active_offsets    (active_offsets),
      .active_phasewords (active_phasewords),
      .dds_reset         (dds_reset),
      .sample_valid      (sample_valid),
      .timeup            (timeup),
      .seg_done          (seg_done),
      .pending           (pending),
      .seg_count         (seg_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N_CH*DW-1:0] amp;
      logic [N_CH*DW-1:0] off;
      logic [N_CH*DW-1:0] ph;
      logic [15:0]        cnt;
   } load_t;

   typedef struct {
      int   len;
      logic idle;
   } seg_t;

   load_t load_q[$];
   seg_t  seg_q[$];

   logic [N_CH*DW-1:0] m_amp = '0, m_off = '0, m_ph = '0;
   logic [15:0]        exp_cnt = '0;
   int                 n_checks = 0;
   int                 n_errors = 0;
   int                 run_len = 0;
   load_t              mon_l;
   seg_t               mon_s;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_bank(input string name, input logic [N_CH*DW-1:0] act,
                             input logic [N_CH*DW-1:0] exp);
      int bad;
      bad = -1;
      for (int i = N_CH - 1; i >= 0; i--)
         if (act[i*DW +: DW] !== exp[i*DW +: DW]) bad = i;
      n_checks++;
      if (bad >= 0) begin
         n_errors++;
         $display("FAIL %s: ch%0d got %h expected %h", name, bad,
                  act[bad*DW +: DW], exp[bad*DW +: DW]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus; a qualifying write also updates the shadow model.
   task automatic cyc(input logic en, input logic [1:0] sel, input logic [5:0] addr,
                      input logic [15:0] data, input logic cmt, input logic [15:0] t,
                      input logic ab);
      wr_en = en; wr_sel = sel; wr_addr = addr; wr_data = data;
      commit = cmt; seg_time = t; abort = ab;
      if (en) begin
         case (sel)
            SEL_AMP:    m_amp[int'(addr)*DW +: DW] = data;
            SEL_OFFSET: m_off[int'(addr)*DW +: DW] = data;
            SEL_PHASE:  m_ph[int'(addr)*DW +: DW]  = data;
            default: ;
         endcase
      end
      tick();
      wr_en = 1'b0; commit = 1'b0; abort = 1'b0;
   endtask

   task automatic push_load();
      load_t l;
      exp_cnt++;
      l.amp = m_amp; l.off = m_off; l.ph = m_ph; l.cnt = exp_cnt;
      load_q.push_back(l);
   endtask

   task automatic push_seg(input int len, input logic idle);
      seg_t s;
      s.len = len; s.idle = idle;
      seg_q.push_back(s);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((load_q.size() != 0 || seg_q.size() != 0) && k < 500) begin
         tick();
         k++;
      end
      check("drain_in_time", 32'(k < 500), 32'd1);
      load_q.delete();
      seg_q.delete();
   endtask

   task automatic check_reset_state();
      check("rst_sample_valid", 32'(sample_valid), 32'd0);
      check("rst_timeup", 32'(timeup), 32'd1);
      check("rst_dds_reset", 32'(dds_reset), 32'd0);
      check("rst_seg_done", 32'(seg_done), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_seg_count", 32'(seg_count), 32'd0);
      check_bank("rst_amps", active_amps, '0);
      check_bank("rst_offsets", active_offsets, '0);
      check_bank("rst_phases", active_phasewords, '0);
   endtask

   // Monitor: a segment record is checked before the load record of the same cycle.
   always @(negedge clk) begin
      if (reset) begin
         run_len = 0;
      end else begin
         if (seg_done) begin
            if (seg_q.size() == 0) begin
               check("unexpected_seg_done", 32'd1, 32'd0);
            end else begin
               mon_s = seg_q.pop_front();
               check("seg_len", 32'(run_len), 32'(mon_s.len));
               check("timeup_at_end", 32'(timeup), 32'(mon_s.idle));
               check("valid_at_end", 32'(sample_valid), 32'(!mon_s.idle));
            end
         end
         if (dds_reset) begin
            if (load_q.size() == 0) begin
               check("unexpected_dds_reset", 32'd1, 32'd0);
            end else begin
               mon_l = load_q.pop_front();
               check_bank("load_amps", active_amps, mon_l.amp);
               check_bank("load_offsets", active_offsets, mon_l.off);
               check_bank("load_phases", active_phasewords, mon_l.ph);
               check("load_seg_count", 32'(seg_count), 32'(mon_l.cnt));
            end
            run_len = 0;
         end
         if (sample_valid) run_len++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      reset = 1'b0;
      tick();

      // Basic segment: 5 valid cycles, phase ch0 = 0100.
      cyc(1'b1, SEL_PHASE, 6'd0, 16'h0100, 1'b0, 16'd0, 1'b0);
      push_load(); push_seg(5, 1'b1);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd4, 1'b0);
      check("basic_pending_clear", 32'(pending), 32'd0);
      check("basic_timeup_low", 32'(timeup), 32'd0);
      wait_drain();
      check("basic_ph0", 32'(active_phasewords[15:0]), 32'h0100);
      check("basic_count", 32'(seg_count), 32'd1);
      check("basic_timeup_back", 32'(timeup), 32'd1);

      // Back-to-back: 4 + 3 cycles, ch63 amp only in the second segment.
      push_load(); push_seg(4, 1'b0);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd3, 1'b0);
      cyc(1'b1, SEL_AMP, 6'd63, 16'h7FFF, 1'b0, 16'd0, 1'b0);
      push_load(); push_seg(3, 1'b1);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd2, 1'b0);
      check("b2b_pending", 32'(pending), 32'd1);
      check("b2b_amp63_old", 32'(active_amps[63*16 +: 16]), 32'h0000);
      wait_drain();
      check("b2b_amp63_new", 32'(active_amps[63*16 +: 16]), 32'h7FFF);
      check("b2b_count", 32'(seg_count), 32'd3);

      // Ignored writes (wr_sel = 3, wr_en low) and T = 0. A 6-bit wr_addr cannot encode 64.
      cyc(1'b1, 2'd3, 6'd5, 16'hDEAD, 1'b0, 16'd0, 1'b0);
      cyc(1'b0, SEL_AMP, 6'd6, 16'hBEEF, 1'b0, 16'd0, 1'b0);
      push_load(); push_seg(1, 1'b1);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd0, 1'b0);
      wait_drain();
      check("bnd_off5", 32'(active_offsets[5*16 +: 16]), 32'h0000);
      check("bnd_amp6", 32'(active_amps[6*16 +: 16]), 32'h0000);

      // Abort in IDLE is ignored; abort at cycle 10 ends the segment.
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b0, 16'd0, 1'b1);
      check("abort_idle_timeup", 32'(timeup), 32'd1);
      cyc(1'b1, SEL_OFFSET, 6'd5, 16'h1234, 1'b0, 16'd0, 1'b0);
      push_load(); push_seg(10, 1'b1);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd100, 1'b0);
      repeat (9) tick();
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b0, 16'd0, 1'b1);
      check("abort_valid_low", 32'(sample_valid), 32'd0);
      check("abort_timeup", 32'(timeup), 32'd1);
      wait_drain();
      check("abort_off5", 32'(active_offsets[5*16 +: 16]), 32'h1234);

      // Abort with a pending bank: gapless swap at cycle 10.
      cyc(1'b1, SEL_AMP, 6'd0, 16'h5555, 1'b0, 16'd0, 1'b0);
      push_load(); push_seg(10, 1'b0);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd100, 1'b0);
      cyc(1'b1, SEL_PHASE, 6'd1, 16'h2222, 1'b0, 16'd0, 1'b0);
      push_load(); push_seg(6, 1'b1);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd5, 1'b0);
      check("abortp_pending", 32'(pending), 32'd1);
      repeat (7) tick();
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b0, 16'd0, 1'b1);
      check("abortp_no_gap", 32'(sample_valid), 32'd1);
      check("abortp_pending_clr", 32'(pending), 32'd0);
      check("abortp_ph1", 32'(active_phasewords[1*16 +: 16]), 32'h2222);
      wait_drain();
      check("abortp_count", 32'(seg_count), 32'd7);

      // Commit plus write on a load edge: old word loads, pending stays, T from new commit.
      cyc(1'b1, SEL_PHASE, 6'd2, 16'h0AAA, 1'b0, 16'd0, 1'b0);
      push_load(); push_seg(4, 1'b0);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd3, 1'b0);
      push_load(); push_seg(2, 1'b0);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd2, 1'b0);
      tick();
      tick();
      cyc(1'b1, SEL_PHASE, 6'd2, 16'h0BBB, 1'b1, 16'd1, 1'b0);
      push_load(); push_seg(2, 1'b1);
      check("sim_pending_kept", 32'(pending), 32'd1);
      check("sim_ph2_old", 32'(active_phasewords[2*16 +: 16]), 32'h0AAA);
      wait_drain();
      check("sim_ph2_new", 32'(active_phasewords[2*16 +: 16]), 32'h0BBB);
      check("sim_pending_clr", 32'(pending), 32'd0);
      check("sim_count", 32'(seg_count), 32'd10);

`ifdef WAVE_SEQ_LOOP_EN
      // Loop: reload every 3 cycles from one commit, then reset mid-segment.
      loop_mode = 1'b1;
      push_load(); push_seg(3, 1'b0);
      push_load(); push_seg(3, 1'b0);
      push_load();
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd2, 1'b0);
      repeat (7) tick();
      check("loop_count", 32'(seg_count), 32'd13);
      check("loop_valid", 32'(sample_valid), 32'd1);
      check("loop_queues", 32'(load_q.size() + seg_q.size()), 32'd0);
      loop_mode = 1'b0;
`else
      push_load();
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd10, 1'b0);
      repeat (3) tick();
      check("pre_reset_valid", 32'(sample_valid), 32'd1);
`endif
      #1;
      reset = 1'b1;
      #1;
      check_reset_state();
      load_q.delete();
      seg_q.delete();
      m_amp = '0; m_off = '0; m_ph = '0; exp_cnt = '0;
      tick();
      reset = 1'b0;
      tick();

      // After reset the shadow is cleared too, so the next load is all zero.
      push_load(); push_seg(1, 1'b1);
      cyc(1'b0, SEL_AMP, 6'd0, 16'h0000, 1'b1, 16'd0, 1'b0);
      wait_drain();
      check("post_reset_count", 32'(seg_count), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
